// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: LANES-wide signed integer ALU behind a 2-stage valid/ready pipeline.
// Build option: define SIMD_ALU_SAT_EN to clamp ADD/SUB/MUL/FMA results instead of wrapping.
module simd_alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [LANES-1:0]         in_mask,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic [LANES*WIDTH-1:0]   in_c,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_result,
    output logic [LANES-1:0]         out_ovf,
    output logic [TAG_W-1:0]         out_tag,
    input  logic                     clr_sticky,
    output logic [LANES-1:0]         ovf_sticky
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_FMA  = 3'd2;
    localparam logic [2:0] OP_MAX  = 3'd3;
    localparam logic [2:0] OP_RELU = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MIN  = 3'd6;

    // Wide enough to hold product + c exactly with a spare sign bit.
    localparam int unsigned XW = 2 * WIDTH + 2;

    logic                     s1_valid, s2_valid, s1_ready, s2_ready;
    logic [2:0]               s1_op;
    logic [LANES-1:0]         s1_mask;
    logic [TAG_W-1:0]         s1_tag;
    logic [LANES*WIDTH-1:0]   s1_a, s1_b, s1_c;
    logic [LANES*2*WIDTH-1:0] s1_prod, prod_d;
    logic [LANES*WIDTH-1:0]   res_d;
    logic [LANES-1:0]         ovf_d;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic signed [2*WIDTH-1:0] xa, xb;
        assign xa = {{WIDTH{in_a[i*WIDTH+WIDTH-1]}}, in_a[i*WIDTH +: WIDTH]};
        assign xb = {{WIDTH{in_b[i*WIDTH+WIDTH-1]}}, in_b[i*WIDTH +: WIDTH]};
        assign prod_d[i*2*WIDTH +: 2*WIDTH] = xa * xb;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WIDTH-1:0] a, b, c;
        logic [2*WIDTH-1:0]      p;
        logic [XW-1:0]           ax, bx, cx, px, exact;
        logic [WIDTH:0]          fsum;
        logic                    mul_ovf, fits;
        logic [WIDTH-1:0]        arith_res, res;
        logic                    ovf;

        assign a  = s1_a[i*WIDTH +: WIDTH];
        assign b  = s1_b[i*WIDTH +: WIDTH];
        assign c  = s1_c[i*WIDTH +: WIDTH];
        assign p  = s1_prod[i*2*WIDTH +: 2*WIDTH];
        assign ax = {{(XW-WIDTH){a[WIDTH-1]}}, a};
        assign bx = {{(XW-WIDTH){b[WIDTH-1]}}, b};
        assign cx = {{(XW-WIDTH){c[WIDTH-1]}}, c};
        assign px = {{2{p[2*WIDTH-1]}}, p};

        assign mul_ovf = (|p[2*WIDTH-1:WIDTH-1]) && !(&p[2*WIDTH-1:WIDTH-1]);
        // FMA overflow is judged on the wrapped product, not the exact one.
        assign fsum = {p[WIDTH-1], p[WIDTH-1:0]} + {c[WIDTH-1], c};

        always_comb begin
            exact = '0;
            case (s1_op)
                OP_ADD:  exact = ax + bx;
                OP_SUB:  exact = ax - bx;
                OP_MUL:  exact = px;
                OP_FMA:  exact = px + cx;
                default: exact = '0;
            endcase
        end

        assign fits = (&exact[XW-1:WIDTH-1]) || !(|exact[XW-1:WIDTH-1]);

`ifdef SIMD_ALU_SAT_EN
        assign arith_res = fits ? exact[WIDTH-1:0] :
                           exact[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                         {1'b0, {(WIDTH-1){1'b1}}};
`else
        assign arith_res = exact[WIDTH-1:0];
`endif

        always_comb begin
            res = '0;
            ovf = 1'b0;
            if (s1_mask[i]) begin
                case (s1_op)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        res = arith_res;
                        ovf = !fits;
                    end
                    OP_FMA: begin
                        res = arith_res;
                        ovf = mul_ovf || (fsum[WIDTH] != fsum[WIDTH-1]);
                    end
                    OP_MAX:  res = (a > b) ? a : b;
                    OP_MIN:  res = (a < b) ? a : b;
                    OP_RELU: res = (!a[WIDTH-1] && (|a)) ? a : '0;
                    default: res = '0;
                endcase
            end
        end

        assign res_d[i*WIDTH +: WIDTH] = res;
        assign ovf_d[i] = ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_mask  <= '0;
            s1_tag   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_prod  <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_mask <= in_mask;
                s1_tag  <= in_tag;
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_c    <= in_c;
                s1_prod <= prod_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_ovf    <= '0;
            out_tag    <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
                out_ovf    <= ovf_d;
                out_tag    <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= '0;
        end else begin
            ovf_sticky <= (clr_sticky ? '0 : ovf_sticky) |
                          ((out_valid && out_ready) ? out_ovf : '0);
        end
    end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Self-checking bench for simd_alu_pipe: directed vectors plus randomized traffic vs. a
// behavioural lane model; honours SIMD_ALU_SAT_EN when defined for both builds.
module tb_simd_alu_pipe;

    localparam int W = 32;
    localparam int L = 4;
    localparam int T = 4;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready, clr_sticky;
    logic [2:0]     in_op;
    logic [L-1:0]   in_mask, out_ovf, ovf_sticky;
    logic [L*W-1:0] in_a, in_b, in_c, out_result;
    logic [T-1:0]   in_tag, out_tag;

    simd_alu_pipe #(.WIDTH(W), .LANES(L), .TAG_W(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mask(in_mask),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_tag(out_tag),
        .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] res;
        logic [L-1:0]   ovf;
        logic [T-1:0]   tag;
    } exp_t;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    logic           acc, ret;
    logic [L*W-1:0] o_res;
    logic [L-1:0]   o_ovf;
    logic [T-1:0]   o_tag;

    function automatic bit out_of_range(input longint v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic [W-1:0] fold(input longint v);
        longint t;
`ifdef SIMD_ALU_SAT_EN
        t = (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
`else
        t = v;
`endif
        return t[W-1:0];
    endfunction

    function automatic void lane_model(input logic [2:0] op, input logic [W-1:0] a, b, c,
                                       output logic [W-1:0] r, output logic v);
        longint sa, sb, sc, p, pl;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        r = '0;
        v = 1'b0;
        case (op)
            3'd0: begin r = fold(sa + sb); v = out_of_range(sa + sb); end
            3'd5: begin r = fold(sa - sb); v = out_of_range(sa - sb); end
            3'd1: begin p = sa * sb; r = fold(p); v = out_of_range(p); end
            3'd2: begin
                p  = sa * sb;
                pl = longint'($signed(p[W-1:0]));
                r  = fold(p + sc);
                v  = out_of_range(p) || out_of_range(pl + sc);
            end
            3'd3: r = (sa > sb) ? a : b;
            3'd6: r = (sa < sb) ? a : b;
            3'd4: r = (sa > 0) ? a : '0;
            default: r = '0;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [L-1:0] m,
                                   input logic [L*W-1:0] a, b, c, input logic [T-1:0] t);
        exp_t e;
        logic [W-1:0] r;
        logic v;
        e.res = '0;
        e.ovf = '0;
        e.tag = t;
        for (int i = 0; i < L; i++) begin
            if (m[i]) begin
                lane_model(op, a[i*W +: W], b[i*W +: W], c[i*W +: W], r, v);
                e.res[i*W +: W] = r;
                e.ovf[i] = v;
            end
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return W'($urandom_range(0, 40));
            6: return -W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [L*W-1:0] rnd_vec();
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = rnd_word();
        return v;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [L-1:0] m,
                         input logic [L*W-1:0] a, b, c, input logic [T-1:0] t);
        in_valid = v; in_op = op; in_mask = m; in_a = a; in_b = b; in_c = c; in_tag = t;
    endtask

    // Sample handshakes and outputs mid-cycle, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        o_res = out_result;
        o_ovf = out_ovf;
        o_tag = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic send_retire(input logic [2:0] op, input logic [L-1:0] m,
                               input logic [W-1:0] a0, b0, c0);
        drive(1'b1, op, m, {{(L-1)*W{1'b0}}, a0}, {{(L-1)*W{1'b0}}, b0},
              {{(L-1)*W{1'b0}}, c0}, '0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready_during: got %0b want 1", in_ready);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_ovf !== '0 || out_tag !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b r=%h o=%b t=%h want all zero",
                     out_valid, out_result, out_ovf, out_tag);
        end
        checks++;
        if (ovf_sticky !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_sticky_ready: got sticky=%b ready=%0b want 0000/1",
                     ovf_sticky, in_ready);
        end
    endtask

    task automatic test_add_mask();
        logic [L*W-1:0] want;
        drive(1'b1, 3'd0, 4'b0011,
              {32'h11, 32'h22, 32'h5, 32'h7FFF_FFFF},
              {32'h3, 32'h4, 32'hFFFF_FFFF, 32'h1}, rnd_vec(), 4'd3);
        out_ready = 1'b1;
`ifdef SIMD_ALU_SAT_EN
        want = {32'h0, 32'h0, 32'h4, 32'h7FFF_FFFF};
`else
        want = {32'h0, 32'h0, 32'h4, 32'h8000_0000};
`endif
        tick();
        in_valid = 1'b0;
        checks++;
        if (!acc || out_valid !== 1'b0) begin
            failures++; $display("FAIL add_latency1: got acc=%0b v=%0b want 1/0", acc, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== want) begin
            failures++; $display("FAIL add_result: got v=%0b %h want 1 %h", out_valid, out_result, want);
        end
        checks++;
        if (out_ovf !== 4'b0001 || out_tag !== 4'd3) begin
            failures++; $display("FAIL add_ovf_tag: got %b/%h want 0001/3", out_ovf, out_tag);
        end
        tick();
    endtask

    task automatic test_ops();
        logic [2:0]   t_op[9] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd6, 3'd4, 3'd5, 3'd7};
        logic [W-1:0] t_a[9]  = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF,
                                  32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [W-1:0] t_b[9]  = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd3, 32'd1,
                                  32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h1234, 32'd1, 32'd6};
        logic [W-1:0] t_c[9]  = '{32'd0, 32'd0, 32'd4, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
`ifdef SIMD_ALU_SAT_EN
        logic [W-1:0] t_r[9]  = '{32'h7FFF_FFFF, 32'd1, 32'hA, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0};
`else
        logic [W-1:0] t_r[9]  = '{32'd0, 32'd1, 32'hA, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0};
`endif
        logic         t_v[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [L*W-1:0] a, b, c, want;
        for (int k = 0; k < 9; k++) begin
            a = rnd_vec(); b = rnd_vec(); c = rnd_vec();
            a[W-1:0] = t_a[k]; b[W-1:0] = t_b[k]; c[W-1:0] = t_c[k];
            drive(1'b1, t_op[k], 4'b0001, a, b, c, T'(k));
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            want = '0;
            want[W-1:0] = t_r[k];
            checks++;
            if (out_valid !== 1'b1 || out_result !== want || out_ovf !== {3'b000, t_v[k]}
                || out_tag !== T'(k)) begin
                failures++;
                $display("FAIL op_vec%0d: got v=%0b r=%h o=%b t=%h want 1 %h %b %h", k, out_valid,
                         out_result, out_ovf, out_tag, want, {3'b000, t_v[k]}, T'(k));
            end
            tick();
        end
    endtask

    task automatic test_random();
        exp_t e, g;
        logic [L-1:0] sticky_m;
        clr_sticky = 1'b1;
        in_valid = 1'b0;
        tick();
        sticky_m = '0;
        for (int n = 0; n < 460; n++) begin
            if (n < 400) begin
                drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
                      rnd_vec(), rnd_vec(), rnd_vec(), 4'($urandom));
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            clr_sticky = ($urandom_range(0, 7) == 0);
            e = model(in_op, in_mask, in_a, in_b, in_c, in_tag);
            tick();
            if (ret) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious: got out_valid with empty scoreboard");
                end else begin
                    g = q.pop_front();
                    if (o_res !== g.res || o_ovf !== g.ovf || o_tag !== g.tag) begin
                        failures++;
                        $display("FAIL rand_result: got %h %b %h want %h %b %h",
                                 o_res, o_ovf, o_tag, g.res, g.ovf, g.tag);
                    end
                    sticky_m = (clr_sticky ? '0 : sticky_m) | g.ovf;
                end
            end else if (clr_sticky) begin
                sticky_m = '0;
            end
            if (acc) q.push_back(e);
            checks++;
            if (ovf_sticky !== sticky_m) begin
                failures++; $display("FAIL rand_sticky: got %b want %b", ovf_sticky, sticky_m);
            end
        end
        clr_sticky = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL rand_drain: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [L*W-1:0] ra[5], rb[5], rc[5];
        exp_t g;
        int idx;
        for (int k = 0; k < 5; k++) begin ra[k] = rnd_vec(); rb[k] = rnd_vec(); rc[k] = rnd_vec(); end
        out_ready = 1'b0;
        idx = 0;
        drive(1'b1, 3'd0, 4'b1111, ra[0], rb[0], rc[0], 4'd1);
        for (int cyc = 0; cyc < 7; cyc++) begin
            tick();
            if (acc) begin
                q.push_back(model(3'd0, 4'b1111, ra[idx], rb[idx], rc[idx], T'(idx + 1)));
                idx++;
                drive(1'b1, 3'd0, 4'b1111, ra[idx], rb[idx], rc[idx], T'(idx + 1));
            end
            if (cyc >= 3) begin
                checks++;
                if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                    out_result !== q[0].res || out_ovf !== q[0].ovf || out_tag !== q[0].tag) begin
                    failures++;
                    $display("FAIL bp_stall: got acc=%0d rdy=%0b v=%0b %h t=%h want 2 0 1 %h t=%h",
                             idx, in_ready, out_valid, out_result, out_tag, q[0].res, q[0].tag);
                end
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (!ret) begin
                failures++; $display("FAIL bp_rate: got no retire at slot %0d want retire", k);
            end else begin
                g = q.pop_front();
                if (o_res !== g.res || o_ovf !== g.ovf || o_tag !== g.tag || o_tag !== T'(k + 1)) begin
                    failures++;
                    $display("FAIL bp_order: got %h t=%h want %h t=%h", o_res, o_tag, g.res, g.tag);
                end
            end
            if (acc) begin
                q.push_back(model(3'd0, 4'b1111, ra[idx], rb[idx], rc[idx], T'(idx + 1)));
                idx++;
                if (idx < 5) drive(1'b1, 3'd0, 4'b1111, ra[idx], rb[idx], rc[idx], T'(idx + 1));
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (q.size() != 0 || idx != 5) begin
            failures++; $display("FAIL bp_count: got pending=%0d issued=%0d want 0/5", q.size(), idx);
        end
        q.delete();
        in_valid = 1'b0;
    endtask

    task automatic test_sticky();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        send_retire(3'd0, 4'b0001, 32'h7FFF_FFFF, 32'h1, 32'h0);
        checks++;
        if (ovf_sticky !== 4'b0001) begin
            failures++; $display("FAIL sticky_set: got %b want 0001", ovf_sticky);
        end
        out_ready = 1'b0;
        drive(1'b1, 3'd5, 4'b0001, {{(L-1)*W{1'b0}}, 32'h8000_0000}, {{(L-1)*W{1'b0}}, 32'h1},
              '0, '0);
        tick();
        in_valid = 1'b0;
        tick();
        clr_sticky = 1'b1;
        out_ready = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++;
        if (!ret || ovf_sticky !== 4'b0001) begin
            failures++; $display("FAIL sticky_set_wins: got ret=%0b %b want 1/0001", ret, ovf_sticky);
        end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++;
        if (ovf_sticky !== 4'b0000) begin
            failures++; $display("FAIL sticky_clear: got %b want 0000", ovf_sticky);
        end
        send_retire(3'd1, 4'b0001, 32'h0001_0000, 32'h0001_0000, 32'h0);
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 4'b1111, rnd_vec(), rnd_vec(), rnd_vec(), 4'd9);
        tick();
        in_tag = 4'd10;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ovf_sticky !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_pre: got v=%0b sticky=%b want 1/0001", out_valid, ovf_sticky);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ovf_sticky !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_immediate: got v=%0b sticky=%b rdy=%0b want 0/0000/1",
                     out_valid, ovf_sticky, in_ready);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (ret || out_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_ghost: got out_valid=1 at cycle %0d want 0", k);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_mask();
        test_ops();
        test_back_to_back();
        test_random();
        test_sticky();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_alu_pipe.md
# simd_alu_pipe

Multi-lane, pipelined integer ALU serving a warp's worth of operands per transaction: LANES independent signed WIDTH-bit lanes execute ADD, SUB, MUL, FMA, MAX, MIN, or RELU under one opcode. It replaces the single-lane combinational ALU inside the execution unit with a 2-stage pipeline. Valid/ready handshakes on both sides, a per-lane execution mask, a passthrough tag, and a sticky per-lane overflow status make it usable behind the warp scheduler under backpressure.

## Interface
- WIDTH, 32, lane data width in bits (>= 4)
- LANES, 4, number of parallel lanes (>= 1)
- TAG_W, 4, width of the passthrough tag (>= 1)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  pipeline can accept a request this cycle
- in_op  input  3  opcode: 0 ADD, 1 MUL, 2 FMA, 3 MAX, 4 RELU, 5 SUB, 6 MIN, 7 reserved
- in_mask  input  LANES  lane enable; bit i gates lane i
- in_a, in_b, in_c  input  LANES*WIDTH  packed operands; lane i at [i*WIDTH +: WIDTH]
- in_tag  input  TAG_W  opaque ID returned with the result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  LANES*WIDTH  packed per-lane results
- out_ovf  output  LANES  per-lane overflow of the presented result
- out_tag  output  TAG_W  tag of the presented result
- clr_sticky  input  1  clears ovf_sticky
- ovf_sticky  output  LANES  sticky per-lane overflow

## Operation
- All arithmetic is signed two's complement, per lane, with no cross-lane interaction.
- ADD: a+b. SUB: a-b. Overflow is signed overflow of the WIDTH-bit result.
- MUL: the full 2*WIDTH signed product is computed. The result is the low WIDTH bits. Overflow when the product is not representable in signed WIDTH.
- FMA: result is (low WIDTH bits of a*b) + c, wrapped. Overflow when the MUL overflows OR the WIDTH-bit addition overflows.
- MAX/MIN: signed compare of a and b. RELU: a if a > 0, else 0. These three never overflow. b and c are ignored where unused.
- Opcode 7: result 0, overflow 0.
- Masked-off lane (in_mask[i]=0): result 0, overflow 0, no sticky update.
- Stage 1 registers the operands, opcode, mask, tag, and the full product.
- Stage 2 registers the add/compare/select results and the overflow flags. out_* are driven directly from stage-2 registers.
- Per-stage handshake:
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready
- Bubbles collapse. A stalled stage holds its contents unchanged.
- ovf_sticky[i] sets when out_valid && out_ready && out_ovf[i]. clr_sticky clears it. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values: out_valid 0, out_result 0, out_ovf 0, out_tag 0, ovf_sticky 0, all stage valids 0. in_ready is 1 while in reset and after it.
- Latency is 2 cycles. A request accepted at edge N is presented with out_valid=1 in the cycle following edge N+1.
- Throughput is 1 request per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 and outputs are stable until accepted.
- in_ready depends combinationally on out_ready; there is no other combinational in-to-out path.
- Accept and retire in the same cycle at full occupancy are legal and sustain throughput.
- Reset asserted mid-operation discards all in-flight requests immediately. No partial results appear after reset deassertion.
- in_* are ignored when in_valid=0 or in_ready=0.

## Configuration
- SIMD_ALU_SAT_EN defined: ADD/SUB/MUL/FMA results are the exact mathematical result clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The exact FMA result is the full product + sign-extended c.
- SIMD_ALU_SAT_EN undefined: results wrap as described above.
- Overflow flag rules and all other behaviour are identical in both builds.

## Test plan
- Reset, then ADD lane0 a=0x7FFFFFFF, b=1; lane1 a=5, b=0xFFFFFFFF; mask 4'b0011; tag 3.
  - Wrap build: lane0 0x80000000 ovf 1; lane1 4 ovf 0; lanes 2-3 result 0 ovf 0; out_tag 3; 2-cycle latency.
  - SAT build: lane0 0x7FFFFFFF.
- MUL 0x10000*0x10000 -> result 0, ovf 1 (SAT build: 0x7FFFFFFF). MUL 0xFFFFFFFF*0xFFFFFFFF -> 1, ovf 0.
- FMA 2*3+4 -> 0xA, ovf 0. FMA 0x7FFFFFFF*1+0x7FFFFFFF -> 0xFFFFFFFE, ovf 1.
- MAX(-1,-2) -> 0xFFFFFFFF. MIN(0x80000000,0x7FFFFFFF) -> 0x80000000. RELU(0x80000000) -> 0. SUB 0x80000000-1 -> ovf 1. Opcode 7 -> 0, ovf 0.
- Backpressure:
  - Issue 5 back-to-back requests with out_ready held 0: in_ready drops after 2 are accepted and out_* stay stable.
  - Release out_ready: all 5 are delivered in order, one per cycle, with matching tags.
- Sticky and reset:
  - Overflowing lane0 result retired -> ovf_sticky[0]=1. clr_sticky in the same cycle as another lane0 overflow retire -> stays 1.
  - Assert rst with 2 requests in flight -> out_valid 0 and ovf_sticky 0 immediately; nothing emerges after release.
